// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage stall/flush controller: owns the PC and the IF/ID register, freezes them on
// load-use stalls, squashes them on redirects, and tracks stall statistics.
module fetch_stall_ctrl #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = 'h00000000,
    parameter logic [XLEN-1:0]   NOP_INSTR  = 'h00000013,
    parameter int                CNT_W      = 16,
    parameter int                MAX_CONSEC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [XLEN-1:0]  target_i,
    input  logic [XLEN-1:0]  imem_instr_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  ifid_pc_o,
    output logic [XLEN-1:0]  ifid_instr_o,
    output logic             ifid_valid_o,
    output logic             bubble_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             stuck_o
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int                     CONSEC_W   = $clog2(MAX_CONSEC + 2);
    localparam logic [CONSEC_W-1:0]    CONSEC_LIM = CONSEC_W'(MAX_CONSEC + 1);

    logic [1:0]          state_reg,      state_next;
    logic [XLEN-1:0]     pc_reg,         pc_next;
    logic [XLEN-1:0]     ifid_pc_reg,    ifid_pc_next;
    logic [XLEN-1:0]     ifid_instr_reg, ifid_instr_next;
    logic                ifid_valid_reg, ifid_valid_next;
    logic                misalign_reg,   misalign_next;
    logic [CNT_W-1:0]    stall_cnt_reg,  stall_cnt_next;
    logic [CONSEC_W-1:0] consec_reg,     consec_next;
    logic                stuck_reg,      stuck_next;
    logic                stall_eff;

    // The first cycle after reset has no valid hazard context, so stall requests are ignored.
    assign stall_eff = stall_i & (state_reg != ST_BOOT);
    assign bubble_o  = stall_eff | flush_i;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_valid_next = ifid_valid_reg;
        misalign_next   = 1'b0;
        stall_cnt_next  = stall_cnt_reg;
        consec_next     = consec_reg;
        stuck_next      = stuck_reg;

        if (flush_i) begin
            // Redirect wins over a simultaneous stall; that stall is neither honoured nor counted.
            pc_next         = {target_i[XLEN-1:2], 2'b00};
            ifid_instr_next = NOP_INSTR;
            ifid_valid_next = 1'b0;
            misalign_next   = |target_i[1:0];
            consec_next     = '0;
            state_next      = ST_RUN;
        end else if (stall_eff) begin
            stall_cnt_next = (stall_cnt_reg == {CNT_W{1'b1}}) ? stall_cnt_reg
                                                              : stall_cnt_reg + 1'b1;
            consec_next    = (consec_reg == CONSEC_LIM) ? consec_reg : consec_reg + 1'b1;
            stuck_next     = stuck_reg | (consec_next == CONSEC_LIM);
            state_next     = ST_HOLD;
        end else begin
            pc_next         = pc_reg + XLEN'(4);
            ifid_pc_next    = pc_reg;
            ifid_instr_next = imem_instr_i;
            ifid_valid_next = 1'b1;
            consec_next     = '0;
            state_next      = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_PC;
            ifid_pc_reg    <= '0;
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            stall_cnt_reg  <= '0;
            consec_reg     <= '0;
            stuck_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_valid_reg <= ifid_valid_next;
            misalign_reg   <= misalign_next;
            stall_cnt_reg  <= stall_cnt_next;
            consec_reg     <= consec_next;
            stuck_reg      <= stuck_next;
        end
    end

    assign pc_o         = pc_reg;
    assign ifid_pc_o    = ifid_pc_reg;
    assign ifid_instr_o = ifid_instr_reg;
    assign ifid_valid_o = ifid_valid_reg;
    assign misalign_o   = misalign_reg;
    assign stall_cnt_o  = stall_cnt_reg;
    assign stuck_o      = stuck_reg;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Scoreboard bench for fetch_stall_ctrl: directed scenarios then random traffic, checked
// against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stall_ctrl;

    localparam int          MAXC = 4;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i;
    logic [31:0] target_i, imem_instr_i;
    logic [31:0] pc_o, ifid_pc_o, ifid_instr_o;
    logic        ifid_valid_o, bubble_o, misalign_o, stuck_o;
    logic [15:0] stall_cnt_o;

    fetch_stall_ctrl dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .target_i(target_i), .imem_instr_i(imem_instr_i),
        .pc_o(pc_o), .ifid_pc_o(ifid_pc_o), .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o), .bubble_o(bubble_o), .misalign_o(misalign_o),
        .stall_cnt_o(stall_cnt_o), .stuck_o(stuck_o)
    );

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed scramble of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A0F0F;
    endfunction

    assign imem_instr_i = imem(pc_o);

    typedef struct {
        logic [31:0] pc, ifid_pc, ifid_instr;
        logic        valid, mis, stuck, bubble;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // Behavioural model: what the fetch stage should show after each edge.
    logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
    logic        m_valid, m_mis, m_stuck;
    int          m_cnt, m_consec;
    bit          m_boot, m_known = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (txn %0d)", name, act, exp, n_txn);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit f, input logic [31:0] t);
        if (r) begin
            m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_valid = 0;
            m_mis = 0; m_cnt = 0; m_consec = 0; m_stuck = 0; m_boot = 1; m_known = 1;
        end else begin
            if (f) begin
                m_pc = {t[31:2], 2'b00};
                m_ifid_instr = NOP;
                m_valid = 0;
                m_mis = (t[1:0] != 2'b00);
                m_consec = 0;
            end else if (s && !m_boot) begin
                m_mis = 0;
                if (m_cnt < 65535) m_cnt++;
                m_consec++;
                if (m_consec > MAXC) m_stuck = 1;
            end else begin
                m_ifid_instr = imem(m_pc);
                m_ifid_pc = m_pc;
                m_pc = m_pc + 32'd4;
                m_valid = 1;
                m_mis = 0;
                m_consec = 0;
            end
            m_boot = 0;
        end
    endtask

    // One clock cycle: drive inputs just after the edge, queue what the DUT should show
    // this cycle, then advance the model past the coming edge.
    task automatic cycle(input bit r, input bit s, input bit f, input logic [31:0] t);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; stall_i = s; flush_i = f; target_i = t;
        if (m_known && !r) begin
            x.pc = m_pc; x.ifid_pc = m_ifid_pc; x.ifid_instr = m_ifid_instr;
            x.valid = m_valid; x.mis = m_mis; x.stuck = m_stuck;
            x.cnt = 16'(m_cnt);
            x.bubble = (s && !m_boot) || f;
            sb.push_back(x);
        end
        model_step(r, s, f, t);
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs; compare mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                check("pc_o",         pc_o,         e.pc);
                check("ifid_instr_o", ifid_instr_o, e.ifid_instr);
                check("ifid_valid_o", {31'b0, ifid_valid_o}, {31'b0, e.valid});
                if (e.valid)
                    check("ifid_pc_o", ifid_pc_o, e.ifid_pc);
                check("misalign_o",   {31'b0, misalign_o},   {31'b0, e.mis});
                check("stall_cnt_o",  {16'b0, stall_cnt_o},  {16'b0, e.cnt});
                check("stuck_o",      {31'b0, stuck_o},      {31'b0, e.stuck});
                check("bubble_o",     {31'b0, bubble_o},     {31'b0, e.bubble});
                $display("txn %0d: pc=%h ifid_pc=%h instr=%h v=%b bub=%b mis=%b cnt=%0d stuck=%b",
                         n_txn, pc_o, ifid_pc_o, ifid_instr_o, ifid_valid_o, bubble_o,
                         misalign_o, stall_cnt_o, stuck_o);
            end
        end
    end

    initial begin
        bit r, s, f;
        logic [31:0] t;
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; target_i = 32'h0;

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        // Free fetch, then a single-cycle stall at pc 8.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // Flush together with stall, then a misaligned redirect.
        cycle(0, 1, 1, 32'h40);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h42);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // Long stall trips the stuck flag, which must persist.
        repeat (5) cycle(0, 1, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        // Reset in the middle of a stall; a stall in the boot cycle is ignored.
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        repeat (7) cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 9) < 4);
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) t = 32'hFFFFFFF0 | t[3:0];
            cycle(r, s, f, t);
        end
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
